// File: rtl/line_buffer_9rows.sv
// Nine-row column tap generator: eight cascaded COLS-deep line delays turn a raster
// pixel stream into vertically aligned taps S1 (8 rows up) .. S9 (current row).
module line_buffer_9rows #(
   parameter int COLS = 11,
   parameter int ROWS = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       done_i,
   input  logic [7:0] data_i,
   output logic [7:0] S1_o,
   output logic [7:0] S2_o,
   output logic [7:0] S3_o,
   output logic [7:0] S4_o,
   output logic [7:0] S5_o,
   output logic [7:0] S6_o,
   output logic [7:0] S7_o,
   output logic [7:0] S8_o,
   output logic [7:0] S9_o,
   output logic       done_o,
   output logic       progress_done_o
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
   localparam logic [RW-1:0] ROW_FILLZ = RW'(7);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [7:0]    tap_q [9];
   logic          done_q;
   logic          prog_q;

   logic [7:0]    line_mem [8][COLS];
   logic [7:0]    rd [8];
   logic          last_col;
   logic          last_row;

   assign last_col = (col_q == COL_LAST);
   assign last_row = (row_q == ROW_LAST);

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         rd[k] = line_mem[k][col_q];
      end
   end

   // Line delays hold no reset: FILL rewrites every entry before STREAM reads it.
   always_ff @(posedge clk) begin
      if (done_i) begin
         line_mem[0][col_q] <= data_i;
         for (int k = 1; k < 8; k++) begin
            line_mem[k][col_q] <= rd[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
         prog_q  <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            tap_q[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         prog_q <= 1'b0;
         if (done_i) begin
            tap_q[8] <= data_i;
            for (int k = 0; k < 8; k++) begin
               tap_q[7-k] <= rd[k];
            end
            col_q <= last_col ? '0 : col_q + 1'b1;
            if (last_col) begin
               row_q <= last_row ? '0 : row_q + 1'b1;
            end
            // IDLE and DONE both accept this pixel as (0,0) of a new frame
            case (state_q)
               IDLE, DONE: state_q <= FILL;
               FILL: begin
                  if (last_col && row_q == ROW_FILLZ) begin
                     state_q <= STREAM;
                  end
               end
               STREAM: begin
                  done_q <= 1'b1;
                  if (last_col && last_row) begin
                     state_q <= DONE;
                     prog_q  <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end else if (state_q == DONE) begin
            state_q <= IDLE;
         end
      end
   end

   assign S1_o            = tap_q[0];
   assign S2_o            = tap_q[1];
   assign S3_o            = tap_q[2];
   assign S4_o            = tap_q[3];
   assign S5_o            = tap_q[4];
   assign S6_o            = tap_q[5];
   assign S7_o            = tap_q[6];
   assign S8_o            = tap_q[7];
   assign S9_o            = tap_q[8];
   assign done_o          = done_q;
   assign progress_done_o = prog_q;

endmodule

// File: tb/tb_line_buffer_9rows.sv
// Directed bench for line_buffer_9rows: an 11x11 instance and a 16x12 instance.
module tb_line_buffer_9rows;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       done1 = 1'b0, done2 = 1'b0;
   logic [7:0] data1 = '0, data2 = '0;
   logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
   logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
   logic       dout1, prog1, dout2, prog2;
   logic [71:0] taps1, taps2;

   assign taps1 = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
   assign taps2 = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

   line_buffer_9rows #(.COLS(11), .ROWS(11)) dut1 (
      .clk(clk), .rst(rst), .done_i(done1), .data_i(data1),
      .S1_o(a1), .S2_o(a2), .S3_o(a3), .S4_o(a4), .S5_o(a5),
      .S6_o(a6), .S7_o(a7), .S8_o(a8), .S9_o(a9),
      .done_o(dout1), .progress_done_o(prog1)
   );

   line_buffer_9rows #(.COLS(16), .ROWS(12)) dut2 (
      .clk(clk), .rst(rst), .done_i(done2), .data_i(data2),
      .S1_o(b1), .S2_o(b2), .S3_o(b3), .S4_o(b4), .S5_o(b5),
      .S6_o(b6), .S7_o(b7), .S8_o(b8), .S9_o(b9),
      .done_o(dout2), .progress_done_o(prog2)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [7:0] pix(input int r, input int c, input bit alt);
      if (alt) return 8'(r * 37 + c * 11 + 5);
      return 8'((r << 4) | c);
   endfunction

   function automatic logic [71:0] exp_taps(input int r, input int c, input bit alt);
      logic [71:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) v[71-8*k -: 8] = pix(r - 8 + k, c, alt);
      return v;
   endfunction

   // Monitor: capture every valid column, count frame pulses, flag any change during stalls
   logic [71:0] q1[$], q2[$];
   int prog_cnt1 = 0, prog_cnt2 = 0, prog_dn1 = 0, prog_dn2 = 0, viol1 = 0, viol2 = 0;
   logic [71:0] prev_t1 = '0, prev_t2 = '0;
   logic prev_d1 = 1'b0, prev_d2 = 1'b0, prev_rst = 1'b1;

   always @(negedge clk) begin
      if (dout1 === 1'b1) q1.push_back(taps1);
      if (dout2 === 1'b1) q2.push_back(taps2);
      if (prog1 === 1'b1) begin prog_cnt1++; if (dout1 === 1'b1) prog_dn1++; end
      if (prog2 === 1'b1) begin prog_cnt2++; if (dout2 === 1'b1) prog_dn2++; end
      if (!rst && !prev_rst && !prev_d1 && (taps1 !== prev_t1 || dout1 !== 1'b0)) viol1++;
      if (!rst && !prev_rst && !prev_d2 && (taps2 !== prev_t2 || dout2 !== 1'b0)) viol2++;
      prev_t1  = taps1;
      prev_t2  = taps2;
      prev_d1  = done1;
      prev_d2  = done2;
      prev_rst = rst;
   end

   task automatic clear_mon();
      q1.delete(); q2.delete();
      prog_cnt1 = 0; prog_cnt2 = 0; prog_dn1 = 0; prog_dn2 = 0;
   endtask

   // Entered and left at posedge+1; each pixel is sampled at the following posedge.
   task automatic feed(input bit alt, input int r, input int c, input int gap);
      while ($urandom_range(99) < gap) begin
         if (alt) done2 = 1'b0; else done1 = 1'b0;
         @(posedge clk); #1;
      end
      if (alt) begin done2 = 1'b1; data2 = pix(r, c, 1'b1); end
      else     begin done1 = 1'b1; data1 = pix(r, c, 1'b0); end
      @(posedge clk); #1;
   endtask

   task automatic frame(input bit alt, input int gap);
      int rows, cols;
      rows = alt ? 12 : 11;
      cols = alt ? 16 : 11;
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) feed(alt, r, c, gap);
   endtask

   task automatic idle(input int n);
      done1 = 1'b0; done2 = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_frames(input bit alt, input int nframes, input string tag);
      int rows, cols, idx, sz;
      logic [71:0] got;
      rows = alt ? 12 : 11;
      cols = alt ? 16 : 11;
      sz   = alt ? q2.size() : q1.size();
      check({tag, "_count"}, 72'(sz), 72'(nframes * (rows - 8) * cols));
      idx = 0;
      for (int f = 0; f < nframes; f++)
         for (int r = 8; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
               got = '0;
               if (idx < sz) got = alt ? q2[idx] : q1[idx];
               check($sformatf("%s_f%0d_r%0d_c%0d", tag, f, r, c), got, exp_taps(r, c, alt));
               idx++;
            end
   endtask

   initial begin
      #2 rst = 1'b1;
      #2;
      check("rst_taps", taps1, '0);
      check("rst_flags", {70'd0, dout1, prog1}, '0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // 1/2: continuous 11x11 frame
      clear_mon();
      frame(1'b0, 0);
      idle(4);
      check_frames(1'b0, 1, "t1");
      if (q1.size() == 33) begin
         check("t1_first_S1", 72'(q1[0][71:64]), 72'h00);
         check("t1_first_S5", 72'(q1[0][39:32]), 72'h40);
         check("t1_first_S9", 72'(q1[0][7:0]),   72'h80);
         check("t1_last_S1",  72'(q1[32][71:64]), 72'h2A);
         check("t1_last_S9",  72'(q1[32][7:0]),   72'hAA);
      end else begin
         check("t1_size_for_taps", 72'(q1.size()), 72'd33);
      end
      check("t2_prog_cnt", 72'(prog_cnt1), 72'd1);
      check("t2_prog_with_done", 72'(prog_dn1), 72'd1);

      // 3: same frame with ~40% stalls
      clear_mon();
      frame(1'b0, 40);
      idle(4);
      check_frames(1'b0, 1, "t3");
      check("t3_prog_cnt", 72'(prog_cnt1), 72'd1);
      check("t3_hold_viol", 72'(viol1), 72'd0);

      // 4: reset at row 5, col 3 then a fresh frame
      clear_mon();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 11; c++) feed(1'b0, r, c, 0);
      for (int c = 0; c < 3; c++) feed(1'b0, 5, c, 0);
      done1 = 1'b0;
      check("t4_pre_rst_S9", 72'(a9), 72'h52);
      rst = 1'b1;
      #1;
      check("t4_rst_taps", taps1, '0);
      check("t4_rst_flags", {70'd0, dout1, prog1}, '0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      check("t4_no_cols_partial", 72'(q1.size()), 72'd0);
      check("t4_no_prog_partial", 72'(prog_cnt1), 72'd0);
      clear_mon();
      frame(1'b0, 0);
      idle(4);
      check_frames(1'b0, 1, "t4");
      check("t4_prog_cnt", 72'(prog_cnt1), 72'd1);

      // 5: two frames back to back, done_i never dropped
      clear_mon();
      frame(1'b0, 0);
      frame(1'b0, 0);
      idle(4);
      check_frames(1'b0, 2, "t5");
      check("t5_prog_cnt", 72'(prog_cnt1), 72'd2);
      check("t5_prog_with_done", 72'(prog_dn1), 72'd2);

      // 6: 16x12 instance with light stalls
      clear_mon();
      frame(1'b1, 20);
      idle(4);
      check_frames(1'b1, 1, "t6");
      check("t6_prog_cnt", 72'(prog_cnt2), 72'd1);
      check("t6_prog_with_done", 72'(prog_dn2), 72'd1);
      check("t6_hold_viol", 72'(viol2), 72'd0);
      check("all_hold_viol1", 72'(viol1), 72'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
